// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX framer.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_PAD,
        ST_CSUM,
        ST_DONE
    } tx_state_t;

    localparam int ETH_HDR_WORDS         = 7;
    localparam int ETH_MIN_PAYLOAD_WORDS = 23;
    localparam int ETH_MAX_PAYLOAD_WORDS = 750;

    function automatic logic [15:0] ones_add16(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/eth_tx_csum.sv
// Ones' complement accumulator over payload words; result is the trailer word.
module eth_tx_csum
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_acc,
    input  logic [15:0] i_data,
    output logic [15:0] o_result
);

    logic [15:0] r_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= 16'd0;
        end else if (i_clr) begin
            r_sum <= 16'd0;
        end else if (i_acc) begin
            r_sum <= ones_add16(r_sum, i_data);
        end
    end

    assign o_result = ~r_sum;

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet II TX framer: header, FIFO payload, zero pad, optional checksum trailer.
// Optional trailer enabled by defining ETH_TX_CSUM_EN.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int MAX_PAYLOAD_WORDS = ETH_MAX_PAYLOAD_WORDS,
    parameter int MIN_PAYLOAD_WORDS = ETH_MIN_PAYLOAD_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  len_words,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] ethertype,
    input  logic [15:0] fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        busy,
    output logic        done,
    output logic        len_err
);

    localparam logic [9:0] LP_MAX = 10'(MAX_PAYLOAD_WORDS);
    localparam logic [9:0] LP_MIN = 10'(MIN_PAYLOAD_WORDS);
    localparam logic [2:0] LP_HDR_LAST = 3'(ETH_HDR_WORDS - 1);

`ifdef ETH_TX_CSUM_EN
    localparam tx_state_t LP_BODY_NEXT = ST_CSUM;
    localparam logic      LP_BODY_EOF  = 1'b0;
`else
    localparam tx_state_t LP_BODY_NEXT = ST_DONE;
    localparam logic      LP_BODY_EOF  = 1'b1;
`endif

    tx_state_t   r_state;
    logic [2:0]  r_hdr_idx;
    logic [9:0]  r_cnt;
    logic [9:0]  r_len;
    logic [47:0] r_dst;
    logic [47:0] r_src;
    logic [15:0] r_type;
    logic [15:0] r_data;
    logic        r_valid;
    logic        r_sof;
    logic        r_eof;
    logic        r_busy;
    logic        r_done;
    logic        r_len_err;

    logic        w_adv;
    logic        w_hs;
    logic        w_pop;
    logic        w_start_ok;
    logic        w_pay_last;
    logic        w_pad_last;
    logic [15:0] w_hdr_word;

    // Output register may be refilled when empty or drained this cycle.
    assign w_adv      = !r_valid || tx_ready;
    assign w_hs       = r_valid && tx_ready;
    assign w_pop      = (r_state == ST_PAY) && !fifo_empty && w_adv;
    assign w_start_ok = (r_state == ST_IDLE) && start && (len_words <= LP_MAX);
    assign w_pay_last = (r_cnt + 10'd1 == r_len);
    assign w_pad_last = (r_cnt + 10'd1 == LP_MIN);

    always_comb begin
        w_hdr_word = r_type;
        unique case (r_hdr_idx)
            3'd1:    w_hdr_word = r_dst[31:16];
            3'd2:    w_hdr_word = r_dst[15:0];
            3'd3:    w_hdr_word = r_src[47:32];
            3'd4:    w_hdr_word = r_src[31:16];
            3'd5:    w_hdr_word = r_src[15:0];
            default: w_hdr_word = r_type;
        endcase
    end

`ifdef ETH_TX_CSUM_EN
    logic [15:0] w_csum;

    eth_tx_csum u_csum (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_start_ok),
        .i_acc    (w_pop),
        .i_data   (fifo_q),
        .o_result (w_csum)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_hdr_idx <= 3'd0;
            r_cnt     <= 10'd0;
            r_len     <= 10'd0;
            r_dst     <= 48'd0;
            r_src     <= 48'd0;
            r_type    <= 16'd0;
            r_data    <= 16'd0;
            r_valid   <= 1'b0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_len_err <= 1'b0;
            if (w_hs) begin
                r_valid <= 1'b0;
                r_sof   <= 1'b0;
                r_eof   <= 1'b0;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (start && !w_start_ok) begin
                        r_len_err <= 1'b1;
                    end else if (w_start_ok) begin
                        r_len     <= len_words;
                        r_dst     <= dst_mac;
                        r_src     <= src_mac;
                        r_type    <= ethertype;
                        r_busy    <= 1'b1;
                        r_valid   <= 1'b1;
                        r_data    <= dst_mac[47:32];
                        r_sof     <= 1'b1;
                        r_eof     <= 1'b0;
                        r_hdr_idx <= 3'd1;
                        r_cnt     <= 10'd0;
                        r_state   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_adv) begin
                        r_valid   <= 1'b1;
                        r_data    <= w_hdr_word;
                        r_sof     <= 1'b0;
                        r_eof     <= 1'b0;
                        r_hdr_idx <= r_hdr_idx + 3'd1;
                        if (r_hdr_idx == LP_HDR_LAST) begin
                            if (r_len != 10'd0) begin
                                r_state <= ST_PAY;
                            end else if (LP_MIN != 10'd0) begin
                                r_state <= ST_PAD;
                            end else begin
                                r_eof   <= LP_BODY_EOF;
                                r_state <= LP_BODY_NEXT;
                            end
                        end
                    end
                end
                ST_PAY: begin
                    if (w_pop) begin
                        r_valid <= 1'b1;
                        r_data  <= fifo_q;
                        r_sof   <= 1'b0;
                        r_eof   <= 1'b0;
                        r_cnt   <= r_cnt + 10'd1;
                        if (w_pay_last) begin
                            if (r_len < LP_MIN) begin
                                r_state <= ST_PAD;
                            end else begin
                                r_eof   <= LP_BODY_EOF;
                                r_state <= LP_BODY_NEXT;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (w_adv) begin
                        r_valid <= 1'b1;
                        r_data  <= 16'd0;
                        r_sof   <= 1'b0;
                        r_eof   <= 1'b0;
                        r_cnt   <= r_cnt + 10'd1;
                        if (w_pad_last) begin
                            r_eof   <= LP_BODY_EOF;
                            r_state <= LP_BODY_NEXT;
                        end
                    end
                end
`ifdef ETH_TX_CSUM_EN
                ST_CSUM: begin
                    if (w_adv) begin
                        r_valid <= 1'b1;
                        r_data  <= w_csum;
                        r_sof   <= 1'b0;
                        r_eof   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
`endif
                // Waits for the eof handshake, then holds one cycle for done.
                ST_DONE: begin
                    if (r_done) begin
                        r_state <= ST_IDLE;
                    end else if (w_hs) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fifo_rdreq = w_pop;
    assign tx_data    = r_data;
    assign tx_valid   = r_valid;
    assign tx_sof     = r_sof;
    assign tx_eof     = r_eof;
    assign busy       = r_busy;
    assign done       = r_done;
    assign len_err    = r_len_err;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer with a show-ahead FIFO model.
module tb_eth_tx_framer;

    localparam int MINW = 23;

    typedef struct packed {
        logic [15:0] d;
        logic        sof;
        logic        eof;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  len_words;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic [15:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sof;
    logic        tx_eof;
    logic        busy;
    logic        done;
    logic        len_err;

    logic [15:0] fmem [0:1023];
    int          frd = 0;
    int          fwr = 0;
    int          exp_rd = 0;
    logic        stall = 1'b0;
    logic        ready_tog = 1'b0;

    exp_t        sbq [$];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          n_hs = 0;
    int          n_done = 0;
    int          cyc = 0;
    int          sof_cyc = 0;
    int          eof_cyc = 0;
    logic        done_pend = 1'b0;
    logic        hold_v = 1'b0;
    logic [15:0] hold_d = 16'd0;
    logic        hold_e = 1'b0;

    eth_tx_framer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len_words  (len_words),
        .dst_mac    (dst_mac),
        .src_mac    (src_mac),
        .ethertype  (ethertype),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_sof     (tx_sof),
        .tx_eof     (tx_eof),
        .busy       (busy),
        .done       (done),
        .len_err    (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_q     = fmem[frd[9:0]];
    assign fifo_empty = (frd == fwr) || stall;

    always @(posedge clk) begin
        if (fifo_rdreq) frd <= frd + 1;
        tx_ready <= ready_tog ? !tx_ready : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            hold_v    = 1'b0;
            done_pend = 1'b0;
        end else begin
            if (done_pend) begin
                chk("done_pulse", {31'd0, done}, 1);
                chk("busy_after_eof", {31'd0, busy}, 0);
                done_pend = 1'b0;
                n_done++;
            end
            if (hold_v) begin
                chk("hold_valid", {31'd0, tx_valid}, 1);
                chk("hold_data", {16'd0, tx_data}, {16'd0, hold_d});
                chk("hold_eof", {31'd0, tx_eof}, {31'd0, hold_e});
            end
            hold_v = tx_valid && !tx_ready;
            hold_d = tx_data;
            hold_e = tx_eof;
            if (fifo_rdreq) begin
                n_pop++;
                chk("pop_nonempty", {31'd0, fifo_empty}, 0);
            end
            if (tx_valid && tx_ready) begin
                if (sbq.size() == 0) begin
                    chk("word_expected", 0, 1);
                end else begin
                    e = sbq.pop_front();
                    chk("tx_data", {16'd0, tx_data}, {16'd0, e.d});
                    chk("tx_sof", {31'd0, tx_sof}, {31'd0, e.sof});
                    chk("tx_eof", {31'd0, tx_eof}, {31'd0, e.eof});
                end
                n_hs++;
                if (tx_sof) sof_cyc = cyc;
                if (tx_eof) begin
                    eof_cyc   = cyc;
                    done_pend = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            fmem[fwr[9:0]] = base + 16'(i);
            fwr++;
        end
    endtask

    function automatic exp_t mk(input logic [15:0] d, input logic s, input logic e);
        exp_t x;
        x.d   = d;
        x.sof = s;
        x.eof = e;
        return x;
    endfunction

    task automatic start_frame(input int len, input logic [47:0] d, input logic [47:0] s,
                               input logic [15:0] t);
        logic [15:0] hw [7];
        int          tot;
        int          nw;
        logic [31:0] acc;
        hw[0] = d[47:32]; hw[1] = d[31:16]; hw[2] = d[15:0];
        hw[3] = s[47:32]; hw[4] = s[31:16]; hw[5] = s[15:0];
        hw[6] = t;
        tot = (len > MINW) ? len : MINW;
`ifdef ETH_TX_CSUM_EN
        nw = 7 + tot + 1;
`else
        nw = 7 + tot;
`endif
        acc = 32'd0;
        for (int i = 0; i < nw; i++) begin
            logic [15:0] w;
            if (i < 7) w = hw[i];
            else if (i < 7 + len) begin
                w   = fmem[10'(exp_rd + i - 7)];
                acc = acc + {16'd0, w};
                acc = {16'd0, acc[15:0]} + {16'd0, acc[31:16]};
            end else if (i < 7 + tot) w = 16'd0;
            else w = ~acc[15:0];
            sbq.push_back(mk(w, i == 0, i == nw - 1));
        end
        exp_rd    = exp_rd + len;
        len_words = 10'(len);
        dst_mac   = d;
        src_mac   = s;
        ethertype = t;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_on_start", {31'd0, busy}, 1);
        chk("valid_on_start", {31'd0, tx_valid}, 1);
        chk("sof_on_start", {31'd0, tx_sof}, 1);
    endtask

    task automatic wait_done(input int len);
        int d0;
        int t;
        d0 = n_done;
        t  = 0;
        while (n_done == d0 && t < 3000) begin
            tick();
            t++;
        end
        chk("frame_done", n_done - d0, 1);
        chk("sb_empty", sbq.size(), 0);
        chk("fifo_rd", frd, exp_rd);
        tick();
        chk("busy_idle", {31'd0, busy}, 0);
        if (len >= 0) chk("done_low", {31'd0, done}, 0);
    endtask

    initial begin
        int p0;
        int t;
        int tot;
        reset     = 1'b1;
        start     = 1'b0;
        len_words = 10'd0;
        dst_mac   = 48'd0;
        src_mac   = 48'd0;
        ethertype = 16'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, tx_valid}, 0);
        chk("rst_sof", {31'd0, tx_sof}, 0);
        chk("rst_eof", {31'd0, tx_eof}, 0);
        chk("rst_data", {16'd0, tx_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_len_err", {31'd0, len_err}, 0);
        chk("rst_rdreq", {31'd0, fifo_rdreq}, 0);
        reset = 1'b0;
        tick();

        preload(30, 16'd1);
        p0 = n_pop;
        start_frame(30, 48'h0011_2233_4455, 48'hA0B1_C2D3_E4F5, 16'h0800);
        wait_done(30);
        chk("pops_30", n_pop - p0, 30);
`ifdef ETH_TX_CSUM_EN
        chk("contig_30", eof_cyc - sof_cyc, 37);
`else
        chk("contig_30", eof_cyc - sof_cyc, 36);
`endif

        preload(5, 16'hA000);
        p0 = n_pop;
        start_frame(5, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h86DD);
        wait_done(5);
        chk("pops_5", n_pop - p0, 5);

        p0 = n_pop;
        start_frame(0, 48'h1234_5678_9ABC, 48'hDEF0_1234_5678, 16'h88B5);
        wait_done(0);
        chk("pops_0", n_pop - p0, 0);

        preload(10, 16'h5A00);
        p0 = n_pop;
        ready_tog = 1'b1;
        start_frame(10, 48'h0A0B_0C0D_0E0F, 48'h1011_1213_1415, 16'h0806);
        t = 0;
        while (n_pop - p0 < 3 && t < 200) begin
            tick();
            t++;
        end
        chk("stall_reached", {31'd0, (n_pop - p0 >= 3)}, 1);
        stall = 1'b1;
        tot   = n_pop;
        repeat (4) tick();
        chk("no_pop_stall", n_pop - tot, 0);
        stall = 1'b0;
        wait_done(10);
        chk("pops_10", n_pop - p0, 10);
        ready_tog = 1'b0;
        tick();

        len_words = 10'd751;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("len_err_pulse", {31'd0, len_err}, 1);
        chk("len_err_busy", {31'd0, busy}, 0);
        chk("len_err_valid", {31'd0, tx_valid}, 0);
        tick();
        chk("len_err_clear", {31'd0, len_err}, 0);
        chk("len_err_idle", {31'd0, busy}, 0);

`ifdef ETH_TX_CSUM_EN
        fmem[fwr[9:0]] = 16'hFFFF;
        fwr++;
        fmem[fwr[9:0]] = 16'h0001;
        fwr++;
        start_frame(2, 48'h0000_0000_0001, 48'h0000_0000_0002, 16'h0800);
        chk("csum_trailer_exp", {16'd0, sbq[sbq.size() - 1].d}, 32'h0000_FFFE);
        wait_done(2);
`endif

        preload(33, 16'hC000);
        p0 = n_hs;
        start_frame(33, 48'h0101_0101_0101, 48'h0202_0202_0202, 16'h0800);
        t = 0;
        while (n_hs - p0 < 12 && t < 500) begin
            tick();
            t++;
        end
        chk("abort_reached", {31'd0, (n_hs - p0 >= 12)}, 1);
        reset = 1'b1;
        #1;
        chk("abort_valid", {31'd0, tx_valid}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_sof", {31'd0, tx_sof}, 0);
        chk("abort_eof", {31'd0, tx_eof}, 0);
        chk("abort_data", {16'd0, tx_data}, 0);
        chk("abort_rdreq", {31'd0, fifo_rdreq}, 0);
        sbq.delete();
        tick();
        tick();
        reset  = 1'b0;
        exp_rd = frd;
        tick();
        p0 = n_pop;
        start_frame(0, 48'hCAFE_0000_BEEF, 48'h0000_1111_2222, 16'h0800);
        wait_done(0);
        chk("pops_after_abort", n_pop - p0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
